display_sequencer: RTL

- Owns the 8-digit BCD display buffer that feeds the display rotator, and drives its displayUpper page select.
- Shares the buffer between two requesters over valid/ready handshakes: keypad digit entry (shift-in) and calculator result load (parallel).
- Accepts a clear request with priority over both requesters.
- While a result is shown, pages automatically between the lower and upper four digits.

---
 rtl/display_sequencer_if.sv | 29 ++
 rtl/display_sequencer.sv | 112 +++++++++++
 2 files changed

// File: rtl/display_sequencer_if.sv
// Handshake and display-bus signals between the digit requesters, the
// sequencer and the display rotator.
interface display_sequencer_if;
    logic        clearReq;
    logic        entryValid;
    logic [3:0]  entryDigit;
    logic        entryReady;
    logic        resultValid;
    logic [31:0] result;
    logic        resultReady;
    logic        pageHold;
    logic [31:0] digitBus;
    logic        displayUpper;
    logic [3:0]  entryCount;
    logic        entryFull;
    logic        entryErr;

    modport slave (
        input  clearReq, entryValid, entryDigit, resultValid, result, pageHold,
        output entryReady, resultReady, digitBus, displayUpper, entryCount,
               entryFull, entryErr
    );

    modport master (
        output clearReq, entryValid, entryDigit, resultValid, result, pageHold,
        input  entryReady, resultReady, digitBus, displayUpper, entryCount,
               entryFull, entryErr
    );
endinterface

// File: rtl/display_sequencer.sv
// Owns the 8-digit BCD display buffer: arbitrates clear > result > keypad entry
// and pages the shown result between its lower and upper four digits.
module display_sequencer #(
    parameter int PAGE_TICKS = 25000000,
    parameter int TW         = 25
) (
    input  logic clk,
    input  logic rst_n,
    display_sequencer_if.slave sq
);
    typedef enum logic [1:0] {EMPTY, ENTRY, RESULT} state_t;

    localparam logic [TW-1:0] LAST_TICK = TW'(PAGE_TICKS - 1);

    state_t        state_q, state_d;
    logic [31:0]   digits_q, digits_d;
    logic [3:0]    count_q, count_d;
    logic          upper_q, upper_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;
    logic          full_q, full_d;

    logic          at_full;
    logic          entry_rdy;
    logic          entry_go;

    // Readiness depends only on other requesters and our own state, never on the
    // requester's own valid.
    assign at_full     = (state_q == ENTRY) && (count_q == 4'd8);
    assign entry_rdy   = !sq.clearReq && !sq.resultValid && !at_full;
    assign entry_go    = sq.entryValid && entry_rdy;

    assign sq.resultReady  = !sq.clearReq;
    assign sq.entryReady   = entry_rdy;
    assign sq.digitBus     = digits_q;
    assign sq.displayUpper = upper_q;
    assign sq.entryCount   = count_q;
    assign sq.entryFull    = full_q;
    assign sq.entryErr     = err_q;

    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        count_d  = count_q;
        upper_d  = 1'b0;
        timer_d  = '0;
        err_d    = 1'b0;

        // Paging runs only while a result is shown; a rejected digit does not disturb it.
        if (state_q == RESULT) begin
            upper_d = upper_q;
            timer_d = timer_q;
            if (!sq.pageHold) begin
                if (timer_q == LAST_TICK) begin
                    timer_d = '0;
                    upper_d = !upper_q;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
        end

        if (sq.clearReq) begin
            state_d  = EMPTY;
            digits_d = '0;
            count_d  = '0;
            upper_d  = 1'b0;
            timer_d  = '0;
        end else if (sq.resultValid) begin
            state_d  = RESULT;
            digits_d = sq.result;
            count_d  = '0;
            upper_d  = 1'b0;
            timer_d  = '0;
        end else if (entry_go) begin
            if (sq.entryDigit > 4'd9) begin
                err_d = 1'b1;
            end else if (state_q != ENTRY) begin
                state_d  = ENTRY;
                digits_d = {28'b0, sq.entryDigit};
                count_d  = 4'd1;
                upper_d  = 1'b0;
                timer_d  = '0;
            end else begin
                digits_d = {digits_q[27:0], sq.entryDigit};
                count_d  = count_q + 4'd1;
            end
        end

        full_d = (count_d == 4'd8);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            digits_q <= '0;
            count_q  <= '0;
            upper_q  <= 1'b0;
            timer_q  <= '0;
            err_q    <= 1'b0;
            full_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            digits_q <= digits_d;
            count_q  <= count_d;
            upper_q  <= upper_d;
            timer_q  <= timer_d;
            err_q    <= err_d;
            full_q   <= full_d;
        end
    end
endmodule
